uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver; the downstream counterpart of the team's uart_tx. Consumes the 1-start / 8-data (LSB first) / 1-stop line and emits one byte per frame with a single-cycle valid strobe.
- The bit period is CLKS_PER_BIT clocks. CLKS_PER_BIT=1 matches uart_tx's one-bit-per-clock line directly, which is the loopback configuration.
- Sits between the pad or uart_tx output and the byte consumer (FIFO or command decoder).

Parameters:
- CLKS_PER_BIT, 1, clocks per serial bit; legal range 1..65535.
- CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- rxd  input  1  serial line; idles high.
- rx_data  output  8  received byte; held stable until the next good frame.
- rx_valid  output  1  one-cycle strobe: rx_data was just updated.
- rx_frame_err  output  1  one-cycle strobe: stop bit sampled low.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: while rst=0 at a rising edge, FSM goes to IDLE and counters clear. Outputs reset to rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_busy=0. Reset mid-frame abandons the frame with no strobe.
- Sampled line s: s is rxd, or the synchronised rxd when the optional feature is enabled.
- Timing origin: t0 is the first cycle in IDLE with s=0. H=(CLKS_PER_BIT-1)/2, integer division.
- Sample points, relative to t0:
  - start-bit check at t0+H; for CLKS_PER_BIT=1 this is t0 itself;
  - data bit i (i=0..7) at t0+H+(i+1)*CLKS_PER_BIT, shifted in LSB first;
  - stop bit at t0+H+9*CLKS_PER_BIT.
- FSM states:
  - IDLE: on s=0, go to START.
  - START: at the check point, if s=1 (glitch), return to IDLE with no strobe; otherwise go to DATA.
  - DATA: collect 8 bits using a 3-bit bit counter; after bit 7, go to STOP.
  - STOP: at the stop sample, if s=1, load rx_data from the shift register, pulse rx_valid and go to IDLE. If s=0, pulse rx_frame_err, leave rx_data unchanged and go to WAIT_HIGH.
  - WAIT_HIGH: stay until s=1, then go to IDLE. This prevents a break or stuck-low line from retriggering.
- Strobe timing: rx_valid or rx_frame_err is high only in the cycle after the stop sample. rx_valid and rx_frame_err are never high together.
- Back-to-back frames: the FSM is already in IDLE in that cycle and accepts a start bit there. A 1-cycle stop followed immediately by the next start bit (uart_tx back-to-back) must be received without loss.
- Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps; it must not overflow CNT_W.
- No flow control: the consumer must take rx_data within one frame time. Any overrun is silent, and rx_data is overwritten by the next good frame.
- rx_busy = (state != IDLE), registered.
- Latency: rx_valid at t0+H+9*CLKS_PER_BIT+1, plus 2 cycles of latency relative to rxd when UART_RX_SYNC_EN is defined.

Optional Feature:
- Macro UART_RX_SYNC_EN.
- Defined: rxd passes through a 2-flop synchroniser, reset to 1'b1, before s. This adds 2 cycles of latency and is required for asynchronous pad inputs.
- Undefined: s=rxd directly, zero added latency. Used for on-chip loopback from uart_tx in the same clock domain.

Decomposition:
- Shared header uart_pkg (included by uart_tx and uart_rx) holds:
  - DATA_BITS=8;
  - IDLE_LEVEL=1'b1;
  - rx state encodings IDLE/START/DATA/STOP/WAIT_HIGH (3-bit).
- Sub-module uart_rx_sync: 2-flop synchroniser with reset-to-1. Instantiated only under UART_RX_SYNC_EN.

Test Plan:
- Reset: hold rst=0 for 3 cycles with rxd toggling -> all outputs 0 and rx_busy=0. Release, rxd=1 for 20 cycles -> no strobes.
- Loopback, CLKS_PER_BIT=1, sync off: uart_tx sends 8'hA5 -> exactly one rx_valid with rx_data=8'hA5, no rx_frame_err.
- Back-to-back, CLKS_PER_BIT=1: uart_tx sends 8'h00 then 8'hFF with tx_trig held -> two rx_valid pulses, data 8'h00 then 8'hFF, no loss.
- Glitch, CLKS_PER_BIT=16: rxd low for 3 cycles then high -> FSM returns to IDLE, no strobes, rx_data unchanged.
- Framing error, CLKS_PER_BIT=16: frame 8'h3C with stop bit driven low for 40 cycles, then high -> one rx_frame_err pulse, no rx_valid, rx_busy stays high until rxd=1. The next good frame 8'h5A is then received.
- Reset mid-frame: assert rst=0 after data bit 3 of 8'hC3, release, send 8'h81 -> no strobe for the aborted frame; rx_data=8'h81 with a single rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and rx FSM state encodings.
// Used by uart_tx and uart_rx.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_STOP = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad.
// Resets to the idle line level so no false start bit appears.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the pad level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= IDLE_LEVEL;
      q <= IDLE_LEVEL;
    end else begin
      meta <= d;
      q <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver, one byte per frame with valid strobe.
// UART_RX_SYNC_EN adds a 2-flop input synchroniser.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic [7:0] rx_data,
  output logic rx_valid,
  output logic rx_frame_err,
  output logic rx_busy
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF =
    (HALF == 0) ? '0 : CNT_W'(HALF - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic s;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk(clk),
    .rst(rst),
    .d(rxd),
    .q(s)
  );
`else
  assign s = rxd;
`endif

  logic [2:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] data_d;
  logic valid_d, ferr_d;

  // Next-state, counters and strobes for the frame FSM.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    data_d = rx_data;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s != IDLE_LEVEL) begin
          cnt_d = '0;
          bit_d = '0;
          // with H=0 the start check is this very cycle
          state_d = (HALF == 0) ? ST_DATA : ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = (s == IDLE_LEVEL) ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d = {s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == BIT_LAST) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (s == IDLE_LEVEL) begin
            data_d = sh_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (s == IDLE_LEVEL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      rx_data <= data_d;
      rx_valid <= valid_d;
      rx_frame_err <= ferr_d;
      rx_busy <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 1 and 16 clocks per bit.
// Drives hand-built frames, monitors strobes against a queue.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rxd1, rxd16;
  logic [7:0] d1, d16;
  logic v1, v16, e1, e16, b1, b16;

  uart_rx #(.CLKS_PER_BIT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .rxd(rxd1),
    .rx_data(d1), .rx_valid(v1),
    .rx_frame_err(e1), .rx_busy(b1)
  );

  uart_rx #(.CLKS_PER_BIT(16), .CNT_W(16)) u16 (
    .clk(clk), .rst(rst), .rxd(rxd16),
    .rx_data(d16), .rx_valid(v16),
    .rx_frame_err(e16), .rx_busy(b16)
  );

  typedef struct packed {
    logic err;
    logic [7:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q16[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // monitor for the 1-clock-per-bit receiver
  always @(negedge clk) begin
    exp_t e;
    if (rst && (v1 || e1)) begin
      check("u1 strobe overlap", 32'(v1 & e1), 0);
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u1 unexpected strobe: valid=%0b err=%0b data=%0h",
                 v1, e1, d1);
      end else begin
        e = q1.pop_front();
        check("u1 strobe kind", 32'(e1), 32'(e.err));
        if (!e.err) check("u1 data", 32'(d1), 32'(e.data));
      end
    end
  end

  // monitor for the 16-clocks-per-bit receiver
  always @(negedge clk) begin
    exp_t e;
    if (rst && (v16 || e16)) begin
      check("u16 strobe overlap", 32'(v16 & e16), 0);
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u16 unexpected strobe: valid=%0b err=%0b data=%0h",
                 v16, e16, d16);
      end else begin
        e = q16.pop_front();
        check("u16 strobe kind", 32'(e16), 32'(e.err));
        if (!e.err) check("u16 data", 32'(d16), 32'(e.data));
      end
    end
  end

  task automatic send1(input logic [7:0] b);
    rxd1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd1 = b[i];
      @(negedge clk);
    end
    rxd1 = 1'b1;
    @(negedge clk);
  endtask

  task automatic send16(input logic [7:0] b,
                        input int stop_cycles,
                        input logic stop_val);
    rxd16 = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd16 = b[i];
      repeat (16) @(negedge clk);
    end
    rxd16 = stop_val;
    repeat (stop_cycles) @(negedge clk);
  endtask

  task automatic drain(input int which);
    int n;
    for (int i = 0; i < 300; i++) begin
      n = (which == 1) ? q1.size() : q16.size();
      if (n == 0) break;
      @(negedge clk);
    end
    n = (which == 1) ? q1.size() : q16.size();
    check((which == 1) ? "u1 drain" : "u16 drain", n, 0);
  endtask

  initial begin
    rst = 1'b0;
    rxd1 = 1'b1;
    rxd16 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd1 = i[0];
      rxd16 = ~i[0];
      @(negedge clk);
    end
    check("u1 reset outputs", {b1, v1, e1, d1}, 0);
    check("u16 reset outputs", {b16, v16, e16, d16}, 0);

    rst = 1'b1;
    rxd1 = 1'b1;
    rxd16 = 1'b1;
    repeat (20) @(negedge clk);
    check("u1 idle busy", 32'(b1), 0);
    check("u16 idle busy", 32'(b16), 0);

    q1.push_back('{1'b0, 8'hA5});
    send1(8'hA5);
    drain(1);
    check("u1 data held A5", 32'(d1), 32'hA5);

    q1.push_back('{1'b0, 8'h00});
    q1.push_back('{1'b0, 8'hFF});
    send1(8'h00);
    send1(8'hFF);
    drain(1);
    repeat (5) @(negedge clk);
    check("u1 b2b idle", 32'(b1), 0);

    q16.push_back('{1'b1, 8'h00});
    send16(8'h3C, 40, 1'b0);
    check("u16 busy in stuck-low", 32'(b16), 1);
    drain(16);
    rxd16 = 1'b1;
    repeat (3) @(negedge clk);
    check("u16 busy after release", 32'(b16), 0);
    check("u16 data after ferr", 32'(d16), 32'h00);
    q16.push_back('{1'b0, 8'h5A});
    send16(8'h5A, 16, 1'b1);
    drain(16);

    rxd16 = 1'b0;
    repeat (3) @(negedge clk);
    rxd16 = 1'b1;
    check("u16 busy during glitch", 32'(b16), 1);
    repeat (20) @(negedge clk);
    check("u16 glitch idle", 32'(b16), 0);
    check("u16 glitch data kept", 32'(d16), 32'h5A);

    rxd16 = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd16 = (i == 0 || i == 1) ? 1'b1 : 1'b0;
      repeat (16) @(negedge clk);
    end
    rst = 1'b0;
    rxd16 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("u16 mid-frame reset", {b16, d16}, 0);
    q16.push_back('{1'b0, 8'h81});
    send16(8'h81, 16, 1'b1);
    drain(16);
    repeat (10) @(negedge clk);
    check("u16 final data", 32'(d16), 32'h81);
    check("u1 final queue", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
